// File: rtl/ahb_master_to_slave_mux_pipe.sv
// AHB-Lite master-to-slave mux with a registered data-phase owner.
// Address/control follow Hmaster; write data follows the owner latched on Hready.
module ahb_master_to_slave_mux_pipe #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  localparam int MASTER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int STRB_W   = DATA_WIDTH / 8
) (
  input  logic                                    Hclk,
  input  logic                                    Hreset,
  input  logic [MASTER_W-1:0]                     Hmaster,
  input  logic                                    Hgrant_valid,
  input  logic                                    Hready,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  Haddr_M,
  input  logic [NUM_MASTERS-1:0][1:0]             Htrans_M,
  input  logic [NUM_MASTERS-1:0]                  Hwrite_M,
  input  logic [NUM_MASTERS-1:0][2:0]             Hsize_M,
  input  logic [NUM_MASTERS-1:0][2:0]             Hburst_M,
  input  logic [NUM_MASTERS-1:0][STRB_W-1:0]      Hstrob_M,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  Hwdata_M,
  output logic [ADDR_WIDTH-1:0]                   Haddr,
  output logic [1:0]                              Htrans,
  output logic                                    Hwrite,
  output logic [2:0]                              Hsize,
  output logic [2:0]                              Hburst,
  output logic [STRB_W-1:0]                       Hstrob,
  output logic [DATA_WIDTH-1:0]                   Hwdata,
  output logic [MASTER_W-1:0]                     Hmaster_data,
  output logic                                    Hdata_active,
  output logic                                    Hdata_write,
  output logic                                    Hhandover_err
);

  localparam logic [MASTER_W:0] NM = (MASTER_W+1)'(NUM_MASTERS);

  logic                addr_ok;
  logic                data_ok_r;
  logic [MASTER_W-1:0] prev_master;
  logic                prev_burst_open;
  logic                prev_seq;
  logic                handover;
  logic                burst_open;

  assign addr_ok = Hgrant_valid && ({1'b0, Hmaster} < NM);

  always_comb begin
    Haddr  = '0;
    Htrans = 2'b00;
    Hwrite = 1'b0;
    Hsize  = 3'b000;
    Hburst = 3'b000;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (addr_ok && Hmaster == MASTER_W'(i)) begin
        Haddr  = Haddr_M[i];
        Htrans = Htrans_M[i];
        Hwrite = Hwrite_M[i];
        Hsize  = Hsize_M[i];
        Hburst = Hburst_M[i];
      end
    end
  end

  always_comb begin
    Hwdata = '0;
    Hstrob = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (data_ok_r && Hmaster_data == MASTER_W'(i)) begin
        Hwdata = Hwdata_M[i];
        Hstrob = Hstrob_M[i];
      end
    end
  end

  // The old owner still driving SEQ means its burst was cut short.
  always_comb begin
    prev_seq = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (prev_master == MASTER_W'(i) && Htrans_M[i] == 2'b11)
        prev_seq = 1'b1;
    end
  end

  assign burst_open = Htrans[1] && (Hburst != 3'b000);
  assign handover   = prev_burst_open && addr_ok &&
                      (Hmaster != prev_master) && prev_seq;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Hmaster_data    <= '0;
      data_ok_r       <= 1'b0;
      Hdata_active    <= 1'b0;
      Hdata_write     <= 1'b0;
      prev_master     <= '0;
      prev_burst_open <= 1'b0;
      Hhandover_err   <= 1'b0;
    end else if (Hready) begin
      Hmaster_data    <= Hmaster;
      data_ok_r       <= addr_ok;
      Hdata_active    <= Htrans[1];
      Hdata_write     <= Htrans[1] && Hwrite;
      prev_master     <= Hmaster;
      prev_burst_open <= burst_open;
      if (handover)
        Hhandover_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_master_to_slave_mux_pipe.sv
// Bench for ahb_master_to_slave_mux_pipe: a 4-master and a 3-master instance
// share stimulus and are compared against a transaction-level reference.
module tb_ahb_master_to_slave_mux_pipe;

  logic hclk = 1'b0;
  logic hreset, hgrant_valid, hready;
  logic [1:0] hmaster;
  logic [3:0][31:0] haddr_m, hwdata_m;
  logic [3:0][1:0] htrans_m;
  logic [3:0] hwrite_m;
  logic [3:0][2:0] hsize_m, hburst_m;
  logic [3:0][3:0] hstrob_m;

  logic [31:0] o_haddr[2], o_hwdata[2];
  logic [1:0] o_htrans[2], o_hmd[2];
  logic o_hwrite[2], o_act[2], o_wr[2], o_err[2];
  logic [2:0] o_hsize[2], o_hburst[2];
  logic [3:0] o_hstrob[2];

  // reference: data-phase owner and burst history per instance
  logic [1:0] m_owner[2], m_prev[2];
  logic m_dok[2], m_act[2], m_wr[2], m_open[2], m_err[2];

  int vectors = 0;
  int miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_master_to_slave_mux_pipe #(.NUM_MASTERS(4)) dut4 (
    .Hclk(hclk), .Hreset(hreset), .Hmaster(hmaster),
    .Hgrant_valid(hgrant_valid), .Hready(hready),
    .Haddr_M(haddr_m), .Htrans_M(htrans_m), .Hwrite_M(hwrite_m),
    .Hsize_M(hsize_m), .Hburst_M(hburst_m), .Hstrob_M(hstrob_m),
    .Hwdata_M(hwdata_m),
    .Haddr(o_haddr[0]), .Htrans(o_htrans[0]), .Hwrite(o_hwrite[0]),
    .Hsize(o_hsize[0]), .Hburst(o_hburst[0]), .Hstrob(o_hstrob[0]),
    .Hwdata(o_hwdata[0]), .Hmaster_data(o_hmd[0]),
    .Hdata_active(o_act[0]), .Hdata_write(o_wr[0]),
    .Hhandover_err(o_err[0])
  );

  ahb_master_to_slave_mux_pipe #(.NUM_MASTERS(3)) dut3 (
    .Hclk(hclk), .Hreset(hreset), .Hmaster(hmaster),
    .Hgrant_valid(hgrant_valid), .Hready(hready),
    .Haddr_M(haddr_m[2:0]), .Htrans_M(htrans_m[2:0]),
    .Hwrite_M(hwrite_m[2:0]), .Hsize_M(hsize_m[2:0]),
    .Hburst_M(hburst_m[2:0]), .Hstrob_M(hstrob_m[2:0]),
    .Hwdata_M(hwdata_m[2:0]),
    .Haddr(o_haddr[1]), .Htrans(o_htrans[1]), .Hwrite(o_hwrite[1]),
    .Hsize(o_hsize[1]), .Hburst(o_hburst[1]), .Hstrob(o_hstrob[1]),
    .Hwdata(o_hwdata[1]), .Hmaster_data(o_hmd[1]),
    .Hdata_active(o_act[1]), .Hdata_write(o_wr[1]),
    .Hhandover_err(o_err[1])
  );

  task automatic idle_all();
    hgrant_valid = 1'b0;
    hready = 1'b1;
    hmaster = 2'd0;
    for (int i = 0; i < 4; i++) begin
      haddr_m[i] = '0; hwdata_m[i] = '0; htrans_m[i] = 2'b00;
      hwrite_m[i] = 1'b0; hsize_m[i] = 3'b010; hburst_m[i] = 3'b000;
      hstrob_m[i] = 4'hF;
    end
  endtask

  // advance reference state by one rising edge, then step past it
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int n;
      logic ok, ps;
      logic [1:0] at;
      logic [2:0] bu;
      n  = (d == 0) ? 4 : 3;
      ok = hgrant_valid && (int'(hmaster) < n);
      at = ok ? htrans_m[hmaster] : 2'b00;
      bu = ok ? hburst_m[hmaster] : 3'b000;
      ps = (int'(m_prev[d]) < n) && (htrans_m[m_prev[d]] == 2'b11);
      if (hreset) begin
        m_owner[d] = 0; m_prev[d] = 0; m_dok[d] = 0; m_act[d] = 0;
        m_wr[d] = 0; m_open[d] = 0; m_err[d] = 0;
      end else if (hready) begin
        if (m_open[d] && ok && hmaster != m_prev[d] && ps) m_err[d] = 1;
        m_owner[d] = hmaster;
        m_dok[d]   = ok;
        m_act[d]   = at[1];
        m_wr[d]    = at[1] && hwrite_m[hmaster];
        m_prev[d]  = hmaster;
        m_open[d]  = at[1] && (bu != 3'b000);
      end
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_htrans[d] !== 2'b00 || o_haddr[d] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_addr d%0d htrans=%b haddr=%h expected 00/0",
                 d, o_htrans[d], o_haddr[d]);
      end
      vectors++;
      if (o_hwdata[d] !== 32'h0 || o_act[d] !== 1'b0 || o_err[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_data d%0d hwdata=%h act=%b err=%b expected 0/0/0",
                 d, o_hwdata[d], o_act[d], o_err[d]);
      end
    end
  endtask

  task automatic test_pipeline();
    idle_all();
    hgrant_valid = 1'b1;
    hmaster = 2'd1;
    htrans_m[1] = 2'b10; hwrite_m[1] = 1'b1; haddr_m[1] = 32'h1000;
    #1;
    vectors++;
    if (o_haddr[0] !== 32'h1000 || o_htrans[0] !== 2'b10) begin
      miscompares++;
      $display("FAIL pipe_addr1 haddr=%h htrans=%b expected 00001000/10",
               o_haddr[0], o_htrans[0]);
    end
    tick();
    hmaster = 2'd2;
    htrans_m[2] = 2'b10; hwrite_m[2] = 1'b1; haddr_m[2] = 32'h2000;
    hwdata_m[1] = 32'hCAFEF00D; hwdata_m[2] = 32'h12345678;
    #1;
    vectors++;
    if (o_haddr[0] !== 32'h2000) begin
      miscompares++;
      $display("FAIL pipe_addr2 haddr=%h expected 00002000", o_haddr[0]);
    end
    vectors++;
    if (o_hwdata[0] !== 32'hCAFEF00D || o_hmd[0] !== 2'd1 || o_wr[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pipe_data hwdata=%h owner=%0d wr=%b expected cafef00d/1/1",
               o_hwdata[0], o_hmd[0], o_wr[0]);
    end
  endtask

  task automatic test_wait_states();
    hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (o_hmd[0] !== 2'd1 || o_hwdata[0] !== 32'hCAFEF00D) begin
        miscompares++;
        $display("FAIL wait_hold%0d owner=%0d hwdata=%h expected 1/cafef00d",
                 k, o_hmd[0], o_hwdata[0]);
      end
    end
    hready = 1'b1;
    tick();
    vectors++;
    if (o_hmd[0] !== 2'd2 || o_hwdata[0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL wait_release owner=%0d hwdata=%h expected 2/12345678",
               o_hmd[0], o_hwdata[0]);
    end
  endtask

  task automatic test_out_of_range();
    idle_all();
    hgrant_valid = 1'b1;
    hmaster = 2'd3;
    htrans_m[3] = 2'b10; hwrite_m[3] = 1'b1; haddr_m[3] = 32'h3000;
    #1;
    vectors++;
    if (o_htrans[1] !== 2'b00 || o_haddr[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_addr htrans=%b haddr=%h expected 00/0",
               o_htrans[1], o_haddr[1]);
    end
    vectors++;
    if (o_haddr[0] !== 32'h3000) begin
      miscompares++;
      $display("FAIL inrange_addr haddr=%h expected 00003000", o_haddr[0]);
    end
    tick();
    hwdata_m[3] = 32'h0BADBEEF;
    hstrob_m[3] = 4'h6;
    #1;
    vectors++;
    if (o_hwdata[1] !== 32'h0 || o_act[1] !== 1'b0 || o_hstrob[1] !== 4'h0) begin
      miscompares++;
      $display("FAIL oor_data hwdata=%h act=%b strb=%h expected 0/0/0",
               o_hwdata[1], o_act[1], o_hstrob[1]);
    end
    vectors++;
    if (o_hwdata[0] !== 32'h0BADBEEF || o_hstrob[0] !== 4'h6) begin
      miscompares++;
      $display("FAIL inrange_data hwdata=%h strb=%h expected 0badbeef/6",
               o_hwdata[0], o_hstrob[0]);
    end
  endtask

  task automatic test_handover();
    idle_all();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    hgrant_valid = 1'b1;
    hmaster = 2'd0;
    htrans_m[0] = 2'b10; hburst_m[0] = 3'b011;
    tick();
    htrans_m[0] = 2'b11;
    hmaster = 2'd1;
    htrans_m[1] = 2'b10;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_err[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL ho_before d%0d err=%b expected 0", d, o_err[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_err[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL ho_set d%0d err=%b expected 1", d, o_err[d]);
      end
    end
    htrans_m[0] = 2'b00; htrans_m[1] = 2'b00;
    tick();
    tick();
    vectors++;
    if (o_err[0] !== 1'b1 || o_haddr[0] !== haddr_m[1]) begin
      miscompares++;
      $display("FAIL ho_sticky err=%b expected 1", o_err[0]);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    vectors++;
    if (o_err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ho_clear err=%b expected 0", o_err[0]);
    end
  endtask

  task automatic test_reset_mid();
    idle_all();
    hgrant_valid = 1'b1;
    hmaster = 2'd3;
    htrans_m[3] = 2'b10; hwrite_m[3] = 1'b1;
    hwdata_m[3] = 32'hA5A55A5A;
    tick();
    vectors++;
    if (o_act[0] !== 1'b1 || o_hmd[0] !== 2'd3 || o_hwdata[0] !== 32'hA5A55A5A) begin
      miscompares++;
      $display("FAIL rmid_pre act=%b owner=%0d hwdata=%h expected 1/3/a5a55a5a",
               o_act[0], o_hmd[0], o_hwdata[0]);
    end
    hready = 1'b0;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    vectors++;
    if (o_act[0] !== 1'b0 || o_hmd[0] !== 2'd0 || o_hwdata[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_post act=%b owner=%0d hwdata=%h expected 0/0/0",
               o_act[0], o_hmd[0], o_hwdata[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      hreset = ($urandom_range(0, 49) == 0);
      hready = ($urandom_range(0, 3) != 0);
      hgrant_valid = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) hmaster = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        haddr_m[i]  = $urandom;
        hwdata_m[i] = $urandom;
        htrans_m[i] = 2'($urandom_range(0, 3));
        hwrite_m[i] = 1'($urandom_range(0, 1));
        hsize_m[i]  = 3'($urandom_range(0, 7));
        hburst_m[i] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        hstrob_m[i] = 4'($urandom_range(0, 15));
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        logic ok;
        logic [31:0] ea, ew;
        logic [1:0] et;
        logic [2:0] es, eb;
        logic [3:0] ek;
        logic ewr;
        ok  = hgrant_valid && (int'(hmaster) < ((d == 0) ? 4 : 3));
        ea  = ok ? haddr_m[hmaster] : 32'h0;
        et  = ok ? htrans_m[hmaster] : 2'b00;
        ewr = ok ? hwrite_m[hmaster] : 1'b0;
        es  = ok ? hsize_m[hmaster] : 3'b000;
        eb  = ok ? hburst_m[hmaster] : 3'b000;
        ew  = m_dok[d] ? hwdata_m[m_owner[d]] : 32'h0;
        ek  = m_dok[d] ? hstrob_m[m_owner[d]] : 4'h0;
        vectors++;
        if (o_haddr[d] !== ea || o_htrans[d] !== et || o_hwrite[d] !== ewr) begin
          miscompares++;
          $display("FAIL rnd_addr c%0d d%0d got %h/%b/%b expected %h/%b/%b",
                   c, d, o_haddr[d], o_htrans[d], o_hwrite[d], ea, et, ewr);
        end
        vectors++;
        if (o_hsize[d] !== es || o_hburst[d] !== eb) begin
          miscompares++;
          $display("FAIL rnd_ctrl c%0d d%0d got %0d/%0d expected %0d/%0d",
                   c, d, o_hsize[d], o_hburst[d], es, eb);
        end
        vectors++;
        if (o_hwdata[d] !== ew || o_hstrob[d] !== ek) begin
          miscompares++;
          $display("FAIL rnd_wdata c%0d d%0d got %h/%h expected %h/%h",
                   c, d, o_hwdata[d], o_hstrob[d], ew, ek);
        end
        vectors++;
        if (o_hmd[d] !== m_owner[d] || o_act[d] !== m_act[d] || o_wr[d] !== m_wr[d]) begin
          miscompares++;
          $display("FAIL rnd_dphase c%0d d%0d got %0d/%b/%b expected %0d/%b/%b",
                   c, d, o_hmd[d], o_act[d], o_wr[d], m_owner[d], m_act[d], m_wr[d]);
        end
        vectors++;
        if (o_err[d] !== m_err[d]) begin
          miscompares++;
          $display("FAIL rnd_err c%0d d%0d got %b expected %b", c, d, o_err[d], m_err[d]);
        end
      end
      tick();
    end
  endtask

  initial begin
    hreset = 1'b1;
    idle_all();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = 0; m_prev[d] = 0; m_dok[d] = 0; m_act[d] = 0;
      m_wr[d] = 0; m_open[d] = 0; m_err[d] = 0;
    end
    test_reset();
    test_pipeline();
    test_wait_states();
    test_out_of_range();
    test_handover();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_master_to_slave_mux_pipe.md
Name: ahb_master_to_slave_mux_pipe

Overview:
- Parametrised AHB-Lite master-to-slave multiplexer with correct address/data phase pipelining for any master count.
- Address and control signals are muxed by the current address-phase owner `Hmaster`.
- `Hwdata` and `Hstrob` are muxed by a registered data-phase owner, which advances only on `Hready`.
- Sits between the arbiter and the address decoder / slave fabric. Also flags illegal mid-burst handovers and reports data-phase state to the slave-to-master path.

Parameters:
- NUM_MASTERS, 4, number of master ports; minimum 1.
- DATA_WIDTH, 32, write data width; must be a multiple of 8.
- ADDR_WIDTH, 32, address width.
- MASTER_W, (NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1), master index width; derived, not overridden.

Ports:
- Hclk  in  1  bus clock; all state updates on its rising edge.
- Hreset  in  1  synchronous reset, active-high.
- Hmaster  in  MASTER_W  address-phase owner index from the arbiter.
- Hgrant_valid  in  1  1 = Hmaster is a valid grant; 0 = no master granted.
- Hready  in  1  global transfer-done signal from the slave mux.
- Haddr_M  in  ADDR_WIDTH x NUM_MASTERS  per-master address.
- Htrans_M  in  2 x NUM_MASTERS  per-master transfer type.
- Hwrite_M  in  1 x NUM_MASTERS  per-master write flag.
- Hsize_M  in  3 x NUM_MASTERS  per-master size.
- Hburst_M  in  3 x NUM_MASTERS  per-master burst type.
- Hstrob_M  in  DATA_WIDTH/8 x NUM_MASTERS  per-master byte strobes (data phase).
- Hwdata_M  in  DATA_WIDTH x NUM_MASTERS  per-master write data (data phase).
- Haddr  out  ADDR_WIDTH  muxed address.
- Htrans  out  2  muxed transfer type.
- Hwrite  out  1  muxed write flag.
- Hsize  out  3  muxed size.
- Hburst  out  3  muxed burst type.
- Hstrob  out  DATA_WIDTH/8  muxed strobes from the data-phase owner.
- Hwdata  out  DATA_WIDTH  muxed write data from the data-phase owner.
- Hmaster_data  out  MASTER_W  registered data-phase owner index.
- Hdata_active  out  1  1 = a NONSEQ/SEQ transfer is in its data phase.
- Hdata_write  out  1  1 = the active data phase is a write.
- Hhandover_err  out  1  sticky flag: grant changed during an unfinished burst.

Behaviour:
- Address phase, combinational:
  - addr_ok = Hgrant_valid && (Hmaster < NUM_MASTERS).
  - If addr_ok: Haddr, Htrans, Hwrite, Hsize and Hburst = the corresponding `*_M[Hmaster]`.
  - Else: Htrans = IDLE (2'b00) and Haddr, Hwrite, Hsize, Hburst = 0.
- Data-phase registers, updated only when Hready = 1; all hold while Hready = 0:
  - Hmaster_data <= Hmaster.
  - data_ok_r <= addr_ok.
  - Hdata_active <= addr_ok && Htrans[1] (NONSEQ 2'b10 or SEQ 2'b11).
  - Hdata_write <= addr_ok && Htrans[1] && Hwrite.
- Data-phase mux, combinational:
  - If data_ok_r: Hwdata = Hwdata_M[Hmaster_data], Hstrob = Hstrob_M[Hmaster_data].
  - Else: Hwdata and Hstrob = 0.
  - Hwdata is valid one Hready-qualified cycle after the address phase; wait states extend it.
- Handover check:
  - prev_master and prev_burst_open are registered on Hready.
  - prev_burst_open = address-phase Htrans was NONSEQ/SEQ with Hburst != SINGLE (3'b000).
  - Hhandover_err sets when all of the following hold in the same cycle:
    - Hready = 1;
    - prev_burst_open = 1;
    - addr_ok && Hmaster != prev_master;
    - Htrans_M[prev_master] == SEQ.
  - Once set, Hhandover_err is cleared only by reset. It is diagnostic; the mux still follows Hmaster.
- Reset (Hreset = 1 at a rising edge) forces:
  - Hmaster_data = 0, data_ok_r = 0, Hdata_active = 0, Hdata_write = 0, prev_burst_open = 0, prev_master = 0, Hhandover_err = 0.
  - Hwdata and Hstrob therefore read 0. Address outputs stay combinational, with IDLE when not granted.
  - Reset mid-burst or during a wait state abandons the data phase: Hdata_active is 0 on the next cycle regardless of Hready.
- Simultaneous events:
  - A grant change while Hready = 0 takes effect on the address outputs immediately.
  - The data-phase owner does not change until Hready = 1.
- NUM_MASTERS = 1: Hmaster is ignored except for the range check; that master is the only valid index.
- No other latency; no buffering of address or control.

Test Plan:
- Reset, then Hgrant_valid = 0 -> Htrans = 00, Haddr = 0, Hwdata = 0, Hdata_active = 0, Hhandover_err = 0.
- Master 1 NONSEQ write, Haddr_M[1] = 0x1000, Hready = 1; next cycle Hmaster = 2 and Hwdata_M[1] = 0xCAFEF00D, Hwdata_M[2] = 0x12345678:
  - Haddr = Haddr_M[2];
  - Hwdata = 0xCAFEF00D;
  - Hmaster_data = 1, Hdata_write = 1.
- Same as above but Hready = 0 for 2 cycles after the address phase -> Hmaster_data stays 1 and Hwdata stays 0xCAFEF00D throughout; switches to master 2 data only after Hready = 1.
- NUM_MASTERS = 3, Hmaster = 3, Hgrant_valid = 1 -> Htrans = 00, Haddr = 0; next data phase Hwdata = 0 and Hdata_active = 0.
- Master 0 INCR4 (NONSEQ then SEQ), Hready = 1, Hmaster switches to 1 while Htrans_M[0] = SEQ -> Hhandover_err = 1 next cycle and stays 1; a subsequent reset clears it.
- Hreset asserted in the data phase of a write from master 3 -> next cycle Hdata_active = 0, Hmaster_data = 0, Hwdata = 0.
